// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal register with parallel load, multi-step
// shift left/right, serial in/out and a start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  request strobe, sampled only while idle
//   mode   00 hold, 01 parallel load, 10 shift left, 11 shift right
//   amt    number of shift steps (shift modes only)
//   d      parallel load data
//   sin    serial fill bit, sampled on every shift edge
//   rot    rotate select (only with SHIFT_REG_UNIV_ROTATE_EN)
//   q      register contents; q_not is its complement
//   sout   last bit shifted out
//   busy   multi-step shift in progress
//   done   one-cycle completion pulse
//
// Optional feature macro: SHIFT_REG_UNIV_ROTATE_EN (rotate instead of fill from sin).
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             sout,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             dir_l;
    logic             dir;
    logic             rot_sel;
    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    logic rot_l;
    // The first shift happens at the start edge, before rot is latched.
    assign rot_sel = (state == IDLE) ? rot : rot_l;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign rot_sel    = 1'b0;
`endif

    // Direction comes live from mode on the start edge, latched afterwards.
    assign dir     = (state == IDLE) ? mode[0] : dir_l;
    assign out_bit = dir ? q[0] : q[WIDTH-1];
    assign fill    = rot_sel ? out_bit : sin;
    assign shifted = dir ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
    assign q_not   = ~q;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            dir_l <= 1'b0;
            q     <= '0;
            sout  <= 1'b0;
            done  <= 1'b0;
`ifdef SHIFT_REG_UNIV_ROTATE_EN
            rot_l <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == SHIFT) begin
                q    <= shifted;
                sout <= out_bit;
                rem  <= rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end else if (start) begin
                if (mode[1] && amt != '0) begin
                    q     <= shifted;
                    sout  <= out_bit;
                    dir_l <= mode[0];
                    rem   <= amt - CNT_W'(1);
                    state <= (amt == CNT_W'(1)) ? IDLE : SHIFT;
                    done  <= (amt == CNT_W'(1));
`ifdef SHIFT_REG_UNIV_ROTATE_EN
                    rot_l <= rot;
`endif
                end else begin
                    q    <= (mode == 2'b01) ? d : q;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule
